vga_timing_rx: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/sync_edge_det.sv | 34 +++
 rtl/vga_timing_rx.sv | 180 ++++++++++++++++++
 tb/tb_vga_timing_rx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module      : vga_timing_pkg
// Description : 640x480 VGA timing constants shared by the sync generator and
//               the sync receiver, plus the receiver lock state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  localparam int VGA_H_TOTAL      = 800;
  localparam int VGA_V_TOTAL      = 525;
  localparam int VGA_H_DISPLAY    = 640;
  localparam int VGA_V_DISPLAY    = 480;
  localparam int VGA_H_SYNC_START = 656;
  localparam int VGA_V_SYNC_START = 490;
  localparam int RX_LOCK_LINES    = 2;

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    HSYNC_OK = 2'd1,
    LOCKED   = 2'd2
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ============================================================================
// Module      : sync_edge_det
// Description : Registers an active-low sync input, keeps a delayed copy and
//               flags the high-to-low (assertion) transition.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sync_n,
  output logic assert_edge
);

  logic r_sample;
  logic r_delay;

  // Idle level is high, so resetting to 1 avoids a false edge after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample <= 1'b1;
      r_delay  <= 1'b1;
    end else begin
      r_sample <= sync_n;
      r_delay  <= r_sample;
    end
  end

  assign assert_edge = r_delay & ~r_sample;

endmodule

`default_nettype wire

// File: rtl/vga_timing_rx.sv
// ============================================================================
// Module      : vga_timing_rx
// Description : Recovers hpos/vpos/display_on from raw active-low hsync/vsync,
//               locking after verified line periods and a vsync alignment.
//               Optional TIMING_RX_STATS_EN adds line_len / frame_lines.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_rx
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL      = VGA_H_TOTAL,
  parameter int V_TOTAL      = VGA_V_TOTAL,
  parameter int H_DISPLAY    = VGA_H_DISPLAY,
  parameter int V_DISPLAY    = VGA_V_DISPLAY,
  parameter int H_SYNC_START = VGA_H_SYNC_START,
  parameter int V_SYNC_START = VGA_V_SYNC_START,
  parameter int LOCK_LINES   = RX_LOCK_LINES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err
`ifdef TIMING_RX_STATS_EN
  ,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines
`endif
);

  localparam logic [9:0] c_h_last    = 10'(H_TOTAL - 1);
  localparam logic [9:0] c_h_total   = 10'(H_TOTAL);
  localparam logic [9:0] c_h_miss    = 10'(H_TOTAL + 1);
  localparam logic [9:0] c_h_sync    = 10'(H_SYNC_START);
  localparam logic [9:0] c_h_align   = 10'(H_SYNC_START + 1);
  localparam logic [9:0] c_v_last    = 10'(V_TOTAL - 1);
  localparam logic [9:0] c_v_sync    = 10'(V_SYNC_START);
  localparam logic [9:0] c_h_disp    = 10'(H_DISPLAY);
  localparam logic [9:0] c_v_disp    = 10'(V_DISPLAY);
  localparam logic [9:0] c_cnt_max   = 10'd1023;
  localparam logic [3:0] c_good_last = 4'(LOCK_LINES - 1);

  rx_state_t  r_state;
  logic [9:0] r_lcnt;
  logic [3:0] r_good;
  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;

  logic       w_h_edge;
  logic       w_v_edge;
  logic       w_h_wrap;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  logic       w_fail;

  sync_edge_det u_hsync_det (
    .clk         (clk),
    .reset       (reset),
    .sync_n      (hsync),
    .assert_edge (w_h_edge)
  );

  sync_edge_det u_vsync_det (
    .clk         (clk),
    .reset       (reset),
    .sync_n      (vsync),
    .assert_edge (w_v_edge)
  );

  // r_hcnt lags the generator by one clock, so an edge lands exactly on the
  // generator position at which the sync was first seen low.
  assign w_h_wrap = (r_hcnt == c_h_last);
  assign w_h_next = w_h_wrap ? 10'd0 : r_hcnt + 10'd1;
  assign w_v_next = (r_vcnt == c_v_last) ? 10'd0 : r_vcnt + 10'd1;

  assign w_fail = (r_state == LOCKED) &&
                  ((w_h_edge && (r_hcnt != c_h_sync)) ||
                   (w_v_edge != ((r_hcnt == 10'd0) && (r_vcnt == c_v_sync))) ||
                   (!w_h_edge && (r_lcnt == c_h_miss)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= SEARCH;
      r_lcnt      <= '0;
      r_good      <= '0;
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      hpos        <= '0;
      vpos        <= '0;
      display_on  <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      r_lcnt <= w_h_edge ? 10'd1 : ((r_lcnt == c_cnt_max) ? r_lcnt : r_lcnt + 10'd1);

      case (r_state)
        SEARCH: begin
          r_hcnt <= w_h_edge ? c_h_align : w_h_next;
          if (w_h_edge) begin
            if (r_lcnt == c_h_total) begin
              if (r_good == c_good_last) begin
                r_good  <= '0;
                r_state <= HSYNC_OK;
              end else begin
                r_good <= r_good + 4'd1;
              end
            end else begin
              r_good <= '0;
            end
          end
        end
        HSYNC_OK: begin
          r_hcnt <= w_h_edge ? c_h_align : w_h_next;
          if (w_h_edge && (r_lcnt != c_h_total)) begin
            r_good  <= '0;
            r_state <= SEARCH;
          end else if (w_v_edge) begin
            r_vcnt  <= c_v_sync;
            r_state <= LOCKED;
          end
        end
        LOCKED: begin
          r_hcnt <= w_h_next;
          if (w_h_wrap) r_vcnt <= w_v_next;
          if (w_fail) begin
            r_good  <= '0;
            r_state <= SEARCH;
          end
        end
        default: r_state <= SEARCH;
      endcase

      // Outputs follow the counters only while locked; otherwise they freeze
      if ((r_state == LOCKED) && !w_fail) begin
        hpos        <= r_hcnt;
        vpos        <= r_vcnt;
        locked      <= 1'b1;
        display_on  <= (r_hcnt < c_h_disp) && (r_vcnt < c_v_disp);
        frame_start <= (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
      end else begin
        locked      <= 1'b0;
        display_on  <= 1'b0;
        frame_start <= 1'b0;
      end

      sync_err <= sync_err | w_fail;
    end
  end

`ifdef TIMING_RX_STATS_EN
  logic [9:0] r_line_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_line_cnt  <= '0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      if (w_h_edge) line_len <= r_lcnt;
      if (w_v_edge) begin
        frame_lines <= r_line_cnt;
        r_line_cnt  <= w_h_edge ? 10'd1 : 10'd0;
      end else if (w_h_edge && (r_line_cnt != c_cnt_max)) begin
        r_line_cnt <= r_line_cnt + 10'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_rx.sv
// ============================================================================
// Module      : tb_vga_timing_rx
// Description : Directed bench for vga_timing_rx with a scaled-down sync
//               generator and a two-deep position scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_rx;

  localparam int TH   = 40;
  localparam int TV   = 20;
  localparam int THD  = 32;
  localparam int TVD  = 15;
  localparam int THS  = 34;
  localparam int TVS  = 17;
  localparam int HSW  = 4;
  localparam int GL_H = 10;

  logic       clk;
  logic       reset;
  logic       hsync;
  logic       vsync;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       locked;
  logic       frame_start;
  logic       sync_err;
`ifdef TIMING_RX_STATS_EN
  logic [9:0] line_len;
  logic [9:0] frame_lines;
`endif

  vga_timing_rx #(
    .H_TOTAL      (TH),
    .V_TOTAL      (TV),
    .H_DISPLAY    (THD),
    .V_DISPLAY    (TVD),
    .H_SYNC_START (THS),
    .V_SYNC_START (TVS),
    .LOCK_LINES   (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hsync       (hsync),
    .vsync       (vsync),
    .hpos        (hpos),
    .vpos        (vpos),
    .display_on  (display_on),
    .locked      (locked),
    .frame_start (frame_start),
    .sync_err    (sync_err)
`ifdef TIMING_RX_STATS_EN
    ,
    .line_len    (line_len),
    .frame_lines (frame_lines)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int gen_h = 0;
  int gen_v = 0;
  int htot = TH;
  bit gen_run = 0;
  bit shift_req = 0;
  int h_off = 0;
  bit glitch_arm = 0;
  bit no_vs = 0;
  int exp_h = 0;
  int exp_v = 0;
  logic [19:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample DUT, pop the position expected now, then drive the
  // generator for the new cycle and push its position.
  task automatic tick();
    logic [19:0] e;
    @(posedge clk);
    #1;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      exp_h = int'(e[19:10]);
      exp_v = int'(e[9:0]);
    end
    if (gen_run) begin
      if (gen_h == htot - 1) begin
        gen_h = 0;
        gen_v = (gen_v == TV - 1) ? 0 : gen_v + 1;
      end else begin
        gen_h++;
      end
      if (gen_h == 0) begin
        h_off = shift_req ? 1 : 0;
        shift_req = 0;
      end
      hsync = !((gen_h >= THS + h_off) && (gen_h < THS + HSW + h_off));
      if (glitch_arm && gen_h == GL_H) begin
        hsync = 1'b0;
        glitch_arm = 0;
      end
      vsync = no_vs || !((gen_v >= TVS) && (gen_v < TVS + 2));
    end
    sb.push_back({gen_h[9:0], gen_v[9:0]});
  endtask

  task automatic wait_lock(input logic want, input int budget, input string tag);
    int n = 0;
    while (locked !== want && n < budget) begin
      tick();
      n++;
    end
    check(tag, locked, want);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs_cnt;
    int n;
    reset = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;
    repeat (3) tick();
    check("rst_hpos", hpos, 0);
    check("rst_vpos", vpos, 0);
    check("rst_disp", display_on, 0);
    check("rst_locked", locked, 0);
    check("rst_fs", frame_start, 0);
    check("rst_err", sync_err, 0);

    // Loopback from a clean generator
    gen_h = TH - 1;
    gen_v = TV - 1;
    gen_run = 1;
    reset = 1'b0;
    wait_lock(1'b1, 2000, "lock_initial");
    check("lock_pt_h", exp_h, 1);
    check("lock_pt_v", exp_v, TVS);
    fs_cnt = 0;
    repeat (2 * TH * TV) begin
      tick();
      check("lb_hpos", hpos, exp_h);
      check("lb_vpos", vpos, exp_v);
      check("lb_disp", display_on, (exp_h < THD) && (exp_v < TVD));
      check("lb_fs", frame_start, (exp_h == 0) && (exp_v == 0));
      check("lb_locked", locked, 1);
      check("lb_err", sync_err, 0);
      if (frame_start === 1'b1) fs_cnt++;
    end
    check("lb_fs_count", fs_cnt, 2);
`ifdef TIMING_RX_STATS_EN
    check("stat_frame_lines", frame_lines, TV);
    check("stat_line_len", line_len, TH);
`endif

    // One hsync edge late by a clock
    shift_req = 1;
    wait_lock(1'b0, 2 * TH, "shift_drop");
    check("shift_pt_h", exp_h, THS + 1);
    check("shift_err", sync_err, 1);
    wait_lock(1'b1, 2 * TH * TV, "shift_relock");
    check("shift_relock_pt_v", exp_v, TVS);
    check("shift_err_sticky", sync_err, 1);

    // Asynchronous reset in the middle of a frame
    n = 0;
    while (gen_v != 5 && n < 2 * TH * TV) begin
      tick();
      n++;
    end
    #2 reset = 1'b1;
    #1;
    check("arst_hpos", hpos, 0);
    check("arst_vpos", vpos, 0);
    check("arst_disp", display_on, 0);
    check("arst_locked", locked, 0);
    check("arst_fs", frame_start, 0);
    check("arst_err", sync_err, 0);
    repeat (3) tick();
    reset = 1'b0;
    wait_lock(1'b1, 2 * TH * TV, "arst_relock");
    check("arst_relock_pt_h", exp_h, 1);
    check("arst_relock_pt_v", exp_v, TVS);
    check("arst_relock_err", sync_err, 0);

    // Vsync missing for one frame
    no_vs = 1;
    wait_lock(1'b0, 2 * TH * TV, "novs_drop");
    check("novs_pt_h", exp_h, 0);
    check("novs_pt_v", exp_v, TVS);
    check("novs_err", sync_err, 1);
    no_vs = 0;

    // Single-clock hsync glitch while locked
    pulse_reset();
    wait_lock(1'b1, 2 * TH * TV, "gl_relock");
    check("gl_err_before", sync_err, 0);
    glitch_arm = 1;
    wait_lock(1'b0, 2 * TH, "gl_drop");
    check("gl_pt_h", exp_h, GL_H);
    check("gl_err", sync_err, 1);
    check("gl_hpos_frozen", hpos, GL_H - 1);
    repeat (5) tick();
    check("gl_hpos_still", hpos, GL_H - 1);
    check("gl_still_unlocked", locked, 0);

    // Lines one clock short never lock
    #2 reset = 1'b1;
    htot = TH - 1;
    gen_h = 0;
    gen_v = 0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (30 * (TH - 1)) begin
      tick();
      check("short_locked", locked, 0);
      check("short_disp", display_on, 0);
      check("short_fs", frame_start, 0);
    end
    check("short_hpos", hpos, 0);
    check("short_err", sync_err, 0);
`ifdef TIMING_RX_STATS_EN
    check("short_line_len", line_len, TH - 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
